poly_ram_reader: RTL and testbench

Streams a full polynomial out of the dual-port coefficient RAM, reading one even/odd coefficient pair per cycle through both RAM ports. It sits directly downstream of the coefficient RAM and feeds pair-oriented consumers such as the NTT butterfly and the pointwise multiplier over a valid/ready stream. It absorbs the RAM's one-cycle read latency and consumer backpressure without losing or duplicating pairs.

---
 rtl/poly_pkg.sv | 6 +
 rtl/poly_ram_reader_if.sv | 16 +
 rtl/pair_skid_buf.sv | 34 +++
 rtl/poly_ram_reader.sv | 88 ++++++++
 tb/tb_poly_ram_reader.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/poly_pkg.sv
// poly_pkg: shared defaults and reader state encoding for polynomial stream blocks.
package poly_pkg;
    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_LENGTH = 512;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} reader_state_t;
endpackage

// File: rtl/poly_ram_reader_if.sv
// poly_ram_reader_if: valid/ready stream of even/odd coefficient pairs.
interface poly_ram_reader_if
    import poly_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = $clog2(DEFAULT_LENGTH)
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_even;
    logic [WIDTH-1:0] out_odd;
    logic [AW-2:0]    out_idx;
    logic             out_last;
    modport master(output out_valid, out_even, out_odd, out_idx, out_last, input out_ready);
    modport slave(input out_valid, out_even, out_odd, out_idx, out_last, output out_ready);
endinterface

// File: rtl/pair_skid_buf.sv
// pair_skid_buf: 2-entry FIFO; the head entry is always visible on dout.
module pair_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [1:0]    occ
);
    logic [DW-1:0] mem [2];
    logic          wp;
    logic          rp;
    assign dout = mem[rp];
    // entries are cleared on reset so an empty buffer presents all-zero outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            occ <= occ + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/poly_ram_reader.sv
// poly_ram_reader: streams a polynomial from a dual-port RAM as even/odd pairs over valid/ready.
module poly_ram_reader
    import poly_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LENGTH = DEFAULT_LENGTH,
    localparam int AW = $clog2(LENGTH),
    localparam int KW = AW - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ram_ena,
    output logic             ram_enb,
    output logic             ram_wea,
    output logic             ram_web,
    output logic [AW-1:0]    ram_addra,
    output logic [AW-1:0]    ram_addrb,
    input  logic [WIDTH-1:0] ram_doa,
    input  logic [WIDTH-1:0] ram_dob,
    poly_ram_reader_if.master out
);
    localparam int DW = 2 * WIDTH + KW + 1;
    localparam logic [KW-1:0] K_LAST = KW'(LENGTH / 2 - 1);
    reader_state_t state, state_nx;
    logic [KW-1:0] k, k_nx, fill_idx;
    logic          inflight, issue, pop, done_nx;
    logic [1:0]    occ;
    logic [DW-1:0] head;
    assign pop = out.out_valid & out.out_ready;
    // a read may issue only if its data is guaranteed a free slot when it lands
    assign issue     = (state == RUN) && (({1'b0, occ} + 3'(inflight)) < (3'd2 + 3'(pop)));
    assign ram_ena   = issue;
    assign ram_enb   = issue;
    assign ram_wea   = 1'b0;
    assign ram_web   = 1'b0;
    assign ram_addra = issue ? {k, 1'b0} : '0;
    assign ram_addrb = issue ? {k, 1'b1} : '0;
    assign busy      = state != IDLE;
    always_comb begin
        state_nx = state;
        k_nx     = k;
        done_nx  = 1'b0;
        case (state)
            IDLE: if (start && !done) begin
                state_nx = RUN;
                k_nx     = '0;
            end
            RUN: if (issue) begin
                k_nx     = (k == K_LAST) ? k : k + KW'(1);
                state_nx = (k == K_LAST) ? DRAIN : RUN;
            end
            DRAIN: if (pop && out.out_last) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k        <= '0;
            fill_idx <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            k        <= k_nx;
            done     <= done_nx;
            inflight <= issue;
            fill_idx <= issue ? k : (state == IDLE && start) ? '0 : fill_idx;
        end
    end
    pair_skid_buf #(.DW(DW)) u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .push (inflight),
        .pop  (pop),
        .din  ({ram_doa, ram_dob, fill_idx, fill_idx == K_LAST}),
        .dout (head),
        .occ  (occ)
    );
    assign {out.out_even, out.out_odd, out.out_idx, out.out_last} = head;
    assign out.out_valid = occ != 2'd0;
endmodule

// File: tb/tb_poly_ram_reader.sv
// tb_poly_ram_reader: randomized directed passes checked against a pair-level reference model.
module tb_poly_ram_reader;
    import poly_pkg::*;
    localparam int WIDTH  = DEFAULT_WIDTH;
    localparam int LENGTH = DEFAULT_LENGTH;
    localparam int AW     = $clog2(LENGTH);
    localparam int NP     = LENGTH / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, ram_ena, ram_enb, ram_wea, ram_web;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [WIDTH-1:0] ram_doa, ram_dob;
    logic [WIDTH-1:0] mem [LENGTH];

    poly_ram_reader_if #(.WIDTH(WIDTH), .AW(AW)) s ();

    poly_ram_reader #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .ram_ena  (ram_ena),
        .ram_enb  (ram_enb),
        .ram_wea  (ram_wea),
        .ram_web  (ram_web),
        .ram_addra(ram_addra),
        .ram_addrb(ram_addrb),
        .ram_doa  (ram_doa),
        .ram_dob  (ram_dob),
        .out      (s)
    );

    always #5 clk = ~clk;

    // synchronous-read RAM: data appears the cycle after enable and holds otherwise
    always @(posedge clk) begin
        if (ram_ena) ram_doa <= mem[ram_addra];
        if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int got = 0;
    int issued = 0;
    int start_cyc = 0;
    int first_valid_edge = 0;
    int last_hs_edge = 0;
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;
    logic stalled = 1'b0;
    logic seen_valid = 1'b0;
    logic [63:0] saved = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ena", 64'(ram_ena), 64'(0));
        chk("rst_enb", 64'(ram_enb), 64'(0));
        chk("rst_addra", 64'(ram_addra), 64'(0));
        chk("rst_addrb", 64'(ram_addrb), 64'(0));
        chk("rst_valid", 64'(s.out_valid), 64'(0));
        chk("rst_even", 64'(s.out_even), 64'(0));
        chk("rst_odd", 64'(s.out_odd), 64'(0));
        chk("rst_idx", 64'(s.out_idx), 64'(0));
        chk("rst_last", 64'(s.out_last), 64'(0));
    endtask

    // one clock: drive inputs, observe away from the edge, advance the reference model
    task automatic cycle(input logic rdy, input logic st);
        logic hs, acc;
        logic [63:0] head_now;
        s.out_ready = rdy;
        start = st;
        #1;
        head_now = 64'({s.out_even, s.out_odd, s.out_idx, s.out_last});
        chk("done", 64'(done), 64'(exp_done));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("we", 64'({ram_wea, ram_web}), 64'(0));
        if (!exp_busy) begin
            chk("idle_ena", 64'(ram_ena), 64'(0));
            chk("idle_valid", 64'(s.out_valid), 64'(0));
        end
        if (stalled) begin
            chk("hold_valid", 64'(s.out_valid), 64'(1));
            chk("hold_data", head_now, saved);
        end
        hs = s.out_valid && rdy;
        if (ram_ena) begin
            chk("enb", 64'(ram_enb), 64'(1));
            chk("addra", 64'(ram_addra), 64'(2 * issued));
            chk("addrb", 64'(ram_addrb), 64'(2 * issued + 1));
            issued++;
            chk("outstanding", 64'(issued - got - int'(hs) <= 2), 64'(1));
            chk("overissue", 64'(issued <= NP), 64'(1));
        end else begin
            chk("enb_off", 64'(ram_enb), 64'(0));
        end
        if (s.out_valid && !seen_valid) begin
            seen_valid = 1'b1;
            first_valid_edge = cyc - 1;
        end
        if (hs) begin
            if (got < NP) begin
                chk("even", 64'(s.out_even), 64'(mem[2 * got]));
                chk("odd", 64'(s.out_odd), 64'(mem[2 * got + 1]));
                chk("idx", 64'(s.out_idx), 64'(got));
                chk("last", 64'(s.out_last), 64'(got == NP - 1));
            end else begin
                chk("extra_pair", 64'(got), 64'(NP - 1));
            end
            got++;
            last_hs_edge = cyc;
        end
        stalled = s.out_valid && !rdy;
        saved = head_now;
        acc = st && !exp_busy && !exp_done;
        exp_done = hs && (got == NP);
        if (exp_done) exp_busy = 1'b0;
        if (acc) begin
            exp_busy = 1'b1;
            got = 0;
            issued = 0;
            start_cyc = cyc;
            seen_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // start a pass and run it up to (not including) the done cycle
    task automatic run_pass(input int prob, input int hold, input int mid);
        int n;
        cycle((hold == 0) && ($urandom_range(99) < prob), 1'b1);
        n = 0;
        while (!exp_done && n < 4000) begin
            if (hold > 0 && n == hold) chk("stall_issues", 64'(issued), 64'(2));
            cycle((n >= hold) && ($urandom_range(99) < prob), n == mid);
            n++;
        end
        if (!exp_done) chk("timeout", 64'(n), 64'(0));
        chk("pairs", 64'(got), 64'(NP));
        chk("latency", 64'(first_valid_edge - start_cyc), 64'(2));
    endtask

    initial begin
        s.out_ready = 1'b0;
        for (int i = 0; i < LENGTH; i++) mem[i] = WIDTH'(i);
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        // full-rate pass over ram[i]=i
        run_pass(100, 0, -1);
        chk("pass_length", 64'(last_hs_edge - start_cyc), 64'(NP + 2));
        cycle(1'b1, 1'b0);
        // random backpressure and data, start mid-pass and on the done cycle
        for (int i = 0; i < LENGTH; i++) mem[i] = WIDTH'($urandom);
        run_pass(50, 0, 37);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0);
        // consumer stalled for 20 cycles after start
        run_pass(100, 20, -1);
        cycle(1'b1, 1'b0);
        // asynchronous reset at pair 100
        cycle(1'b1, 1'b1);
        for (int n = 0; n < 1000 && got < 100; n++) cycle(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        stalled = 1'b0;
        got = 0;
        issued = 0;
        repeat (2) cycle(1'b1, 1'b0);
        rst_n = 1'b1;
        run_pass(100, 0, -1);
        // back-to-back passes with new contents loaded between them
        for (int i = 0; i < LENGTH; i++) mem[i] = WIDTH'($urandom);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < LENGTH; i++) mem[i] = WIDTH'($urandom);
        run_pass(70, 0, -1);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < LENGTH; i++) mem[i] = WIDTH'($urandom);
        run_pass(70, 0, -1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
